// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// New frames are double-buffered and applied only at the frame wrap.
module seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DWELL_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 2000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            load_valid,
   output logic                            load_ready,
   input  logic [4*NUM_DIGITS-1:0]         load_data,
   input  logic [NUM_DIGITS-1:0]           load_en,
   output logic [3:0]                      nums,
   output logic [NUM_DIGITS-1:0]           an,
   output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
   output logic                            frame_tick
);

   localparam int unsigned IW      = $clog2(NUM_DIGITS);
   localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam bit            HAS_BLANK  = (BLANK_CYCLES > 0);

   typedef enum logic {S_SHOW, S_BLANK} state_t;

   state_t                    r_state;
   logic [CW-1:0]             r_cnt;
   logic [4*NUM_DIGITS-1:0]   r_act_data;
   logic [NUM_DIGITS-1:0]     r_act_en;
   logic [4*NUM_DIGITS-1:0]   r_pend_data;
   logic [NUM_DIGITS-1:0]     r_pend_en;
   logic                      r_pend_full;

   logic                      w_dwell_done;
   logic                      w_blank_done;
   logic                      w_advance;
   logic                      w_to_blank;
   logic                      w_wrap;
   logic                      w_commit;
   logic                      w_take;
   logic [IW-1:0]             w_next_idx;
   logic [4*NUM_DIGITS-1:0]   w_src_data;
   logic [NUM_DIGITS-1:0]     w_src_en;
   logic [NUM_DIGITS-1:0]     w_an_show;
   logic [3:0]                w_nums_show;

   // Slot sequencing and the display image for the slot being entered
   always_comb begin
      w_dwell_done = (r_state == S_SHOW)  && (r_cnt == DWELL_LAST);
      w_blank_done = (r_state == S_BLANK) && (r_cnt == BLANK_LAST);
      w_advance    = (w_dwell_done && !HAS_BLANK) || w_blank_done;
      w_to_blank   = w_dwell_done && HAS_BLANK;
      w_next_idx   = (digit_idx == LAST_IDX) ? '0 : digit_idx + IW'(1);
      w_wrap       = w_advance && (digit_idx == LAST_IDX);
      w_commit     = w_wrap && r_pend_full;
      w_take       = load_valid && load_ready;
      // On a committing wrap, digit 0 must already show the new frame
      w_src_data   = w_commit ? r_pend_data : r_act_data;
      w_src_en     = w_commit ? r_pend_en   : r_act_en;
      w_nums_show  = w_src_data[4*int'(w_next_idx) +: 4];
      w_an_show    = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         w_an_show[k] = ~(w_src_en[k] && (w_next_idx == IW'(k)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_SHOW;
         r_cnt       <= '0;
         r_act_data  <= '0;
         r_act_en    <= '0;
         r_pend_data <= '0;
         r_pend_en   <= '0;
         r_pend_full <= 1'b0;
         an          <= '1;
         nums        <= '0;
         digit_idx   <= '0;
         frame_tick  <= 1'b0;
         load_ready  <= 1'b1;
      end else begin
         frame_tick <= w_wrap;
         // Ready drops with the capture and recovers one cycle after the commit
         load_ready <= ~(w_take | r_pend_full);

         if (w_commit) begin
            r_act_data <= r_pend_data;
            r_act_en   <= r_pend_en;
         end
         if (w_take) begin
            r_pend_data <= load_data;
            r_pend_en   <= load_en;
            r_pend_full <= 1'b1;
         end else if (w_commit) begin
            r_pend_full <= 1'b0;
         end

         if (w_to_blank) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            an      <= '1;
         end else if (w_advance) begin
            r_state   <= S_SHOW;
            r_cnt     <= '0;
            digit_idx <= w_next_idx;
            an        <= w_an_show;
            nums      <= w_nums_show;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a cycle model pushes expected outputs to a
// queue on each clock edge and the DUT outputs are popped and compared 1ns later.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int D     = 4;
   localparam int B     = 1;
   localparam int SLOT  = D + B;
   localparam int FRAME = N * SLOT;

   logic        clk;
   logic        rst_n;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  load_en;
   logic [3:0]  nums;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   seg_scan_ctrl #(
      .NUM_DIGITS   (N),
      .DWELL_CYCLES (D),
      .BLANK_CYCLES (B)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_en    (load_en),
      .nums       (nums),
      .an         (an),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] nums;
      logic [1:0] idx;
      logic       tick;
      logic       ready;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int          m_pos;
   logic [15:0] m_act_data, m_pend_data;
   logic [3:0]  m_act_en, m_pend_en;
   logic        m_pend_full, m_ready, m_tick, m_took;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      int   slot;
      int   sub;
      slot   = m_pos / SLOT;
      sub    = m_pos % SLOT;
      e.an   = 4'hF;
      if (sub < D) e.an[slot] = ~m_act_en[slot];
      e.nums  = m_act_data[4*slot +: 4];
      e.idx   = 2'(slot);
      e.tick  = m_tick;
      e.ready = m_ready;
      return e;
   endfunction

   task automatic model_reset();
      m_pos       = 0;
      m_act_data  = '0;
      m_act_en    = '0;
      m_pend_data = '0;
      m_pend_en   = '0;
      m_pend_full = 1'b0;
      m_ready     = 1'b1;
      m_tick      = 1'b0;
      m_took      = 1'b0;
   endtask

   task automatic compare_pop();
      exp_t e;
      if (q.size() == 0) begin
         check("queue_empty", 16'(q.size()), 16'd1);
      end else begin
         e = q.pop_front();
         check("an",         16'(an),         16'(e.an));
         check("nums",       16'(nums),       16'(e.nums));
         check("digit_idx",  16'(digit_idx),  16'(e.idx));
         check("frame_tick", 16'(frame_tick), 16'(e.tick));
         check("load_ready", 16'(load_ready), 16'(e.ready));
      end
   endtask

   // One clock: update model with the inputs seen at the edge, then compare
   task automatic cycle();
      logic take;
      logic ready_n;
      @(posedge clk);
      take    = load_valid && m_ready;
      ready_n = !(take || m_pend_full);
      m_pos   = (m_pos + 1) % FRAME;
      m_tick  = (m_pos == 0);
      if (m_pos == 0 && m_pend_full) begin
         m_act_data  = m_pend_data;
         m_act_en    = m_pend_en;
         m_pend_full = 1'b0;
      end
      if (take) begin
         m_pend_data = load_data;
         m_pend_en   = load_en;
         m_pend_full = 1'b1;
      end
      m_ready = ready_n;
      m_took  = take;
      q.push_back(model_out());
      #1;
      compare_pop();
   endtask

   task automatic wait_take();
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!m_took && n < 60);
      check("load_accept_timeout", 16'(m_took), 16'd1);
   endtask

   task automatic run_until_pos(input int p);
      int n;
      n = 0;
      while (m_pos != p && n < 2*FRAME) begin
         cycle();
         n++;
      end
      check("pos_timeout", 16'(m_pos), 16'(p));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_en    = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an",    16'(an),         16'hF);
      check("rst_ready", 16'(load_ready), 16'd1);
      check("rst_idx",   16'(digit_idx),  16'd0);
      check("rst_nums",  16'(nums),       16'd0);
      check("rst_tick",  16'(frame_tick), 16'd0);
      rst_n = 1'b1;
      q.push_back(model_out());
      compare_pop();

      // Idle, then first load offered in cycle 3
      repeat (3) cycle();
      load_valid = 1'b1;
      load_data  = 16'h4321;
      load_en    = 4'hF;
      cycle();
      load_valid = 1'b0;
      repeat (40) cycle();

      // Back-to-back loads: the second waits for the wrap
      load_valid = 1'b1;
      load_data  = 16'hAAAA;
      load_en    = 4'hF;
      wait_take();
      load_data  = 16'hBBBB;
      wait_take();
      load_valid = 1'b0;
      repeat (45) cycle();

      // Partial enable mask keeps digits 1 and 3 dark
      load_valid = 1'b1;
      load_data  = 16'h5678;
      load_en    = 4'b0101;
      wait_take();
      load_valid = 1'b0;
      repeat (45) cycle();

      // Load accepted on the wrap edge lands one frame later
      run_until_pos(FRAME - 1);
      load_valid = 1'b1;
      load_data  = 16'h9ABC;
      load_en    = 4'hF;
      cycle();
      check("wrap_take", 16'(m_took), 16'd1);
      load_valid = 1'b0;
      repeat (42) cycle();

      // Reset mid digit 2 SHOW with a frame pending
      load_valid = 1'b1;
      load_data  = 16'hDEF0;
      load_en    = 4'hF;
      wait_take();
      load_valid = 1'b0;
      run_until_pos(2*SLOT + 1);
      check("pre_rst_an", 16'(an), 16'b1011);
      rst_n = 1'b0;
      #1;
      check("async_rst_an",    16'(an),         16'hF);
      check("async_rst_idx",   16'(digit_idx),  16'd0);
      check("async_rst_ready", 16'(load_ready), 16'd1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      q.push_back(model_out());
      compare_pop();
      repeat (2*FRAME + 2) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits.
- All digits share one 4-bit hex decoder; this block drives the decoder input `nums` with one digit's value at a time.
- It enables that digit's anode for a fixed dwell, then blanks all anodes before moving on, which suppresses ghosting.
- New display contents arrive via a valid/ready load port and are applied only at frame boundaries, so a frame never shows a mix of old and new values (no tearing).

Parameters:
- NUM_DIGITS, 4, digits scanned; range 2..8.
- DWELL_CYCLES, 100000, clk cycles each digit is driven in SHOW; must be ≥2.
- BLANK_CYCLES, 2000, clk cycles all anodes are off between digits; 0 removes the BLANK state.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  new frame data offered
- load_ready  out  1  controller can accept a frame
- load_data  in  4*NUM_DIGITS  digit values; digit i = load_data[4i+3:4i]
- load_en  in  NUM_DIGITS  per-digit enable; 0 keeps that digit dark
- nums  out  4  value to the shared hex decoder
- an  out  NUM_DIGITS  anode enables, active low
- digit_idx  out  $clog2(NUM_DIGITS)  digit currently selected
- frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), all state cleared immediately on assertion.
- Reset values:
  - an = all 1s; nums = 0; digit_idx = 0; frame_tick = 0; load_ready = 1.
  - Active and pending registers = 0; pending_full = 0; state = SHOW; dwell counter = 0.
- All outputs are registered.
- Registers:
  - Active set (data, en) drives the display.
  - Pending set (data, en, pending_full) holds an accepted but not yet applied frame.
- FSM states: SHOW, BLANK.
  - SHOW (digit i): an[i] = ~active_en[i]; all other anodes = 1; nums = active_data[i]. Lasts exactly DWELL_CYCLES cycles.
  - SHOW exit: → BLANK if BLANK_CYCLES > 0, else advance directly.
  - BLANK: an = all 1s; nums holds its last value. Lasts exactly BLANK_CYCLES cycles, then advance.
  - Advance: i ← i+1, wrapping NUM_DIGITS-1 → 0.
- Counter: a single down/up counter of width $clog2(max(DWELL,BLANK)+1), reloaded on every state change. It never overflows and has no terminal-count off-by-one: each dwell is exactly the parameter value.
- Frame length = NUM_DIGITS × (DWELL_CYCLES + BLANK_CYCLES) cycles.
- Wrap event (advance from the last digit to 0):
  - frame_tick = 1 in the first cycle of digit 0's SHOW.
  - If pending_full, then in that same first cycle: active ← pending, pending_full ← 0, and digit 0 shows the new data.
- Load handshake:
  - load_ready = ~pending_full.
  - Transfer occurs on load_valid & load_ready: capture data/en into pending; pending_full = 1 from the next cycle.
  - load_valid with ready low: no effect; the source holds its data and waits.
  - Transfer in the same cycle as the wrap commit: the commit uses the old pending contents (pending was empty, so nothing commits); the new data is captured and applied at the following wrap. There is no bypass.
  - load_ready returns high the cycle after a commit.
- At most one frame is buffered. A second load is back-pressured until the next wrap.
- Reset mid-scan: display goes dark immediately (async). Any pending frame is discarded; the scan restarts at digit 0 in SHOW.
- The block does not decode segments; the downstream decoder owns polarity of the segment lines.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1, frame = 20 cycles):
- Reset then idle 40 cycles -> an stays 4'b1111 (enables 0). digit_idx sequence 0,1,2,3 with 5-cycle period. frame_tick pulses at cycles 20 and 40 after reset release.
- Load data=16'h4321, en=4'hF at cycle 3 -> load_ready low from cycle 4. At cycle 20: an=4'b1110, nums=1 for 4 cycles, then an=4'b1111 for 1 cycle, then an=4'b1101, nums=2. load_ready high at cycle 21.
- Two loads offered back-to-back (16'hAAAA then 16'hBBBB) -> second held (ready=0) until wrap. Frame 1 shows A, frame 2 shows B; no frame ever mixes A and B digits.
- Load en=4'b0101 -> digits 1 and 3 keep an bit = 1 during their SHOW slots; digits 0 and 2 light. Slot timing is unchanged.
- Load accepted in the exact wrap cycle -> not visible in the current frame; committed at the next frame_tick.
- Assert rst_n low during digit 2 SHOW with a pending frame -> an = 4'b1111 within the same cycle. After release: digit_idx=0, load_ready=1, active data=0.
